// File: rtl/output_arbiter.sv
// Per-output-port round-robin arbiter for the 5-port mesh router.
// Collects the request bits raised by the five input interfaces for this output,
// moves the winning flit into a one-flit output register, pulses the winner's
// buffer-clear and drives the so/ro handshake toward the downstream link.
module output_arbiter #(
  parameter int unsigned          DATA_WIDTH = 64,
  parameter int unsigned          NUM_PORTS  = 5,
  parameter logic [NUM_PORTS-1:0] DIRECTION  = 5'b00001
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] dataI,
  input  logic                            ro,
  output logic                            so,
  output logic [DATA_WIDTH-1:0]           datao,
  output logic [NUM_PORTS-1:0]            buffer_clear,
  output logic [NUM_PORTS-1:0]            grant
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // DIRECTION only identifies the instance; arbitration never looks at it.
  if (DIRECTION == '0) begin : g_dir_untagged
  end else begin : g_dir_tagged
  end

  state_t                 state;
  state_t                 state_d;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_d;
  logic                   so_d;
  logic [DATA_WIDTH-1:0]  datao_d;
  logic [NUM_PORTS-1:0]   grant_d;
  logic [NUM_PORTS-1:0]   clear_d;

  logic [NUM_PORTS-1:0]   eligible;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [NUM_PORTS-1:0]   win_onehot;
  logic                   load;
  logic [DATA_WIDTH-1:0]  flit [NUM_PORTS];

  // Split the flattened input bus into one flit per port
  always_comb begin : flit_unpack
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      flit[i] = dataI[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A port whose clear pulse is live may still show req for one more cycle; mask it
  assign eligible = req & ~buffer_clear;

  // Round-robin winner search starting just after the last granted port
  always_comb begin : winner_search
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
      idx = (32'(ptr) + off) % NUM_PORTS;
      if (!win_found && eligible[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign win_onehot = NUM_PORTS'(1) << win_idx;

  // Next-state and next-output logic; the output register is refilled whenever it
  // is empty or is being drained at this edge
  always_comb begin : next_state
    state_d = state;
    ptr_d   = ptr;
    so_d    = so;
    datao_d = datao;
    grant_d = grant;
    clear_d = '0;
    load    = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          load = 1'b1;
        end
      end
      SEND: begin
        if (ro) begin
          if (win_found) begin
            load = 1'b1;
          end else begin
            so_d    = 1'b0;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      datao_d = flit[win_idx];
      grant_d = win_onehot;
      clear_d = win_onehot;
      so_d    = 1'b1;
      ptr_d   = win_idx;
      state_d = SEND;
    end
  end

  // State, pointer and output registers; reset drops any held flit at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= PTR_W'(NUM_PORTS - 1);
      so           <= 1'b0;
      datao        <= '0;
      grant        <= '0;
      buffer_clear <= '0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      so           <= so_d;
      datao        <= datao_d;
      grant        <= grant_d;
      buffer_clear <= clear_d;
    end
  end

endmodule
